dmem_ctrl: RTL and testbench

- Data-memory controller directly downstream of the load/store unit in the M stage.
- Consumes the LSU request (cs, wr, mask, addr, data_wr), performs byte-lane-masked writes and full-word reads on an internal word array with fixed multi-cycle latency, and returns the read word to the LSU on data_rd.
- Asserts stall to the hazard unit so M (and upstream stages) hold while an access is in flight.

---
 rtl/dmem_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - M-stage data-memory controller with fixed-latency masked stores and word loads (optional: DMEM_RANGE_CHECK_EN)
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
`ifdef DMEM_RANGE_CHECK_EN
  output logic        fault,
`endif
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_wr;
  logic [3:0]    r_mask;
  logic [31:0]   r_addr;
  logic [31:0]   r_data;
  logic [31:0]   r_data_rd;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_req;
  logic          w_stall;
  logic          w_go_done;
  logic          w_c_wr;
  logic [3:0]    w_c_mask;
  logic [31:0]   w_c_addr;
  logic [31:0]   w_c_data;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_unused;

  assign w_req = (r_state == S_IDLE) && !cs;

  // With LATENCY == 1 the commit edge is the request edge itself, so the
  // commit path takes the live inputs in IDLE and the latched copy otherwise.
  assign w_c_wr   = (r_state == S_IDLE) ? wr      : r_wr;
  assign w_c_mask = (r_state == S_IDLE) ? mask    : r_mask;
  assign w_c_addr = (r_state == S_IDLE) ? addr    : r_addr;
  assign w_c_data = (r_state == S_IDLE) ? data_wr : r_data;
  assign w_idx    = w_c_addr[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
  logic r_fault;
  assign w_oor = ({32'd0, w_c_addr} >= (64'(DEPTH_WORDS) * 64'd4));
  assign fault = r_fault;

  // Fault flag is high only in the DONE cycle of an out-of-range access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fault <= 1'b0;
    else     r_fault <= w_go_done && w_oor;
  end
`else
  assign w_oor = 1'b0;
`endif

  // Byte offset and alias bits are intentionally ignored by the word index
  assign w_unused = ^{w_c_addr[1:0], w_c_addr[31:AW+2]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and stall decode; DONE always returns to IDLE so a held cs
  // cannot re-issue the same instruction
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!cs) begin
          w_stall = 1'b1;
          w_next  = (LATENCY == 1) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_go_done = (w_next == S_DONE);
  end

  assign stall   = w_stall && !rst;
  assign data_rd = r_data_rd;

  // Request capture and BUSY countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr   <= 1'b0;
      r_mask <= 4'd0;
      r_addr <= 32'd0;
      r_data <= 32'd0;
      r_cnt  <= 4'd0;
    end else if (w_req) begin
      r_wr   <= wr;
      r_mask <= mask;
      r_addr <= addr;
      r_data <= data_wr;
      r_cnt  <= CNT_INIT;
    end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
      r_cnt  <= r_cnt - 4'd1;
    end
  end

  // Load result register, updated only when a load commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_rd <= 32'd0;
    end else if (w_go_done && w_c_wr) begin
      r_data_rd <= w_oor ? 32'd0 : r_mem[w_idx];
    end
  end

  // Byte-lane store commit; array contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && w_go_done && !w_c_wr && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_c_mask[i]) r_mem[w_idx][8*i +: 8] <= w_c_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        stall;
`ifdef DMEM_RANGE_CHECK_EN
  logic        fault;
`endif

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .wr      (wr),
    .mask    (mask),
    .addr    (addr),
    .data_wr (data_wr),
    .data_rd (data_rd),
`ifdef DMEM_RANGE_CHECK_EN
    .fault   (fault),
`endif
    .stall   (stall)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = 32'd0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_oor(input logic [31:0] a);
`ifdef DMEM_RANGE_CHECK_EN
    return a >= 32'(DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Issue one access starting at posedge+1; returns at posedge+1 of the IDLE
  // cycle that follows DONE, with cs still low so the caller can chain.
  task automatic access(input logic w, input logic [3:0] m, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble, input string tag);
    int          n = 0;
    bit          done = 1'b0;
    logic [31:0] cur;
    logic [31:0] exp;
    if (w) begin
      exp = is_oor(a) ? 32'd0 : (model.exists(widx(a)) ? model[widx(a)] : 32'd0);
      exp_q.push_back(exp);
    end else if (!is_oor(a)) begin
      cur = model.exists(widx(a)) ? model[widx(a)] : 32'd0;
      for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[widx(a)] = cur;
    end
    cs = 1'b0; wr = w; mask = m; addr = a; data_wr = d;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
`ifdef DMEM_RANGE_CHECK_EN
      check_val({tag, "_fault_busy"}, 32'(fault), 32'd0);
`endif
      @(posedge clk);
      #1;
      if (scramble) begin
        addr = a ^ 32'h0000_0004; data_wr = ~d; mask = 4'hF; wr = ~w;
      end
    end
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_stall_cycles"}, 32'(n), 32'(LAT));
    if (w) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check_val({tag, "_rd"}, data_rd, exp);
        last_rd = exp;
      end
    end else begin
      check_val({tag, "_rd_hold"}, data_rd, last_rd);
    end
`ifdef DMEM_RANGE_CHECK_EN
    check_val({tag, "_fault_done"}, 32'(fault), 32'(is_oor(a)));
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int k, input string tag);
    cs = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check_val({tag, "_stall"}, 32'(stall), 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
      check_val({tag, "_fault"}, 32'(fault), 32'd0);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; wr = 1'b1; mask = 4'h0; addr = 32'd0; data_wr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_stall", 32'(stall), 32'd0);
    check_val("reset_rd", data_rd, 32'd0);
`ifdef DMEM_RANGE_CHECK_EN
    check_val("reset_fault", 32'(fault), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic store then load, back to back
    access(1'b0, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, "st10");
    access(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, "ld10");
    check_val("ld10_const", data_rd, 32'hDEADBEEF);

    // Lane merge
    access(1'b0, 4'hF, 32'h20, 32'hAABBCCDD, 1'b0, "st20a");
    access(1'b0, 4'b0010, 32'h20, 32'h00001100, 1'b0, "st20b");
    access(1'b1, 4'h0, 32'h20, 32'h0, 1'b0, "ld20");
    check_val("ld20_const", data_rd, 32'hAABB11DD);

    // Mask zero writes nothing, unaligned byte offset ignored
    access(1'b0, 4'hF, 32'h24, 32'h12345678, 1'b0, "st24");
    access(1'b0, 4'h0, 32'h24, 32'hFFFFFFFF, 1'b0, "st24m0");
    access(1'b1, 4'h0, 32'h27, 32'h0, 1'b0, "ld24");
    check_val("ld24_const", data_rd, 32'h12345678);

    // Inputs changed during BUSY are ignored
    access(1'b0, 4'hF, 32'h40, 32'h55AA55AA, 1'b0, "st40");
    access(1'b0, 4'hF, 32'h44, 32'h00000099, 1'b1, "st44scr");
    access(1'b1, 4'h0, 32'h40, 32'h0, 1'b0, "ld40");
    check_val("ld40_const", data_rd, 32'h55AA55AA);
    access(1'b1, 4'h0, 32'h44, 32'h0, 1'b0, "ld44");
    check_val("ld44_const", data_rd, 32'h00000099);
    idle_cycles(3, "idle1");

    // Reset during BUSY drops the store
    access(1'b0, 4'hF, 32'h30, 32'h00000000, 1'b0, "st30");
    access(1'b1, 4'h0, 32'h10, 32'h0, 1'b0, "ld10b");
    cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h30; data_wr = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    check_val("rst_busy_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    check_val("rst_async_stall", 32'(stall), 32'd0);
    check_val("rst_async_rd", data_rd, 32'd0);
    last_rd = 32'd0;
    cs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(1'b1, 4'h0, 32'h30, 32'h0, 1'b0, "ld30");
    check_val("ld30_const", data_rd, 32'h0);

    // Out-of-range: alias in default build, fault and suppression with range check
    access(1'b0, 4'hF, 32'h0, 32'h01020304, 1'b0, "st0");
    access(1'b1, 4'h0, 32'h1000, 32'h0, 1'b0, "ld1000");
    access(1'b0, 4'hF, 32'h1000, 32'hCAFEF00D, 1'b0, "st1000");
    access(1'b1, 4'h0, 32'h0, 32'h0, 1'b0, "ld0");
`ifdef DMEM_RANGE_CHECK_EN
    check_val("ld0_const", data_rd, 32'h01020304);
`else
    check_val("ld0_const", data_rd, 32'hCAFEF00D);
`endif
    idle_cycles(2, "idle2");

    // Randomised traffic over a small window of words
    for (int i = 0; i < 8; i++)
      access(1'b0, 4'hF, 32'h100 + 32'(4 * i), $urandom, 1'b0, "rinit");
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      ra = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        access(1'b1, 4'h0, ra, 32'h0, 1'b0, "rld");
      else
        access(1'b0, 4'($urandom_range(0, 15)), ra, $urandom, $urandom_range(0, 1) == 1, "rst_");
    end
    idle_cycles(2, "idle3");
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
